// File: rtl/w_bit_serializer_if.sv
// Word-in / bit-out bundle between a parallel word producer and the w-line serializer.
// The producer holds the master side; the serializer holds the slave side.
interface w_bit_serializer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]         in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic                     w;
   logic                     w_active;
   logic                     busy;
   logic [$clog2(DEPTH):0]   fifo_level;
   logic [15:0]              words_sent;

   modport master (
      output in_data, in_valid,
      input  in_ready, w, w_active, busy, fifo_level, words_sent
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, w, w_active, busy, fifo_level, words_sent
   );
endinterface

// File: rtl/w_bit_serializer.sv
// Buffers parallel words in a small FIFO and shifts them onto the serial line w, one bit per
// clock, with back-to-back words chained without an idle gap.
module w_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter bit IDLE_BIT  = 1'b1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   w_bit_serializer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [CW-1:0]    bit_cnt, bit_cnt_next;
   logic             w_reg, w_next;
   logic             active_reg, active_next;
   logic [15:0]      sent;
   logic             push, pop, word_done, can_accept;
   logic [WIDTH-1:0] head, head_rest, shreg_rest;
   logic             head_first, shreg_first;

   assign can_accept = (level < FULL_LEVEL);
   assign push       = bus.in_valid && can_accept;
   assign head       = mem[rd_ptr];

   // shreg keeps the not-yet-sent bits aligned so the next bit always sits at the output end
   assign head_first  = MSB_FIRST ? head[WIDTH-1]  : head[0];
   assign head_rest   = MSB_FIRST ? (head << 1)    : (head >> 1);
   assign shreg_first = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
   assign shreg_rest  = MSB_FIRST ? (shreg << 1)   : (shreg >> 1);

   always_comb begin
      state_next   = state;
      w_next       = w_reg;
      active_next  = active_reg;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      pop          = 1'b0;
      word_done    = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               pop          = 1'b1;
               w_next       = head_first;
               active_next  = 1'b1;
               bit_cnt_next = CW'(1);
               shreg_next   = head_rest;
               state_next   = SHIFT;
            end else begin
               w_next      = IDLE_BIT;
               active_next = 1'b0;
            end
         end
         SHIFT: begin
            if (bit_cnt != LAST_CNT) begin
               w_next       = shreg_first;
               shreg_next   = shreg_rest;
               bit_cnt_next = bit_cnt + 1'b1;
            end else begin
               // last bit has had its cycle; chain straight into the next word if one waits
               word_done = 1'b1;
               if (level != '0) begin
                  pop          = 1'b1;
                  w_next       = head_first;
                  bit_cnt_next = CW'(1);
                  shreg_next   = head_rest;
               end else begin
                  w_next       = IDLE_BIT;
                  active_next  = 1'b0;
                  bit_cnt_next = '0;
                  state_next   = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         w_reg      <= IDLE_BIT;
         active_reg <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         sent       <= '0;
      end else begin
         state      <= state_next;
         w_reg      <= w_next;
         active_reg <= active_next;
         bit_cnt    <= bit_cnt_next;
         shreg      <= shreg_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         sent <= sent + 16'(word_done);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= bus.in_data;
   end

   assign bus.in_ready   = can_accept;
   assign bus.w          = w_reg;
   assign bus.w_active   = active_reg;
   assign bus.busy       = active_reg | (level != '0);
   assign bus.fifo_level = level;
   assign bus.words_sent = sent;
endmodule

// File: tb/tb_w_bit_serializer.sv
// Directed bench for w_bit_serializer: one MSB-first instance and one LSB-first instance,
// plus a behavioural Q6 detector chained onto the MSB-first serial line.
module tb_w_bit_serializer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   w_bit_serializer_if #(.WIDTH(8), .DEPTH(4)) bus ();
   w_bit_serializer_if #(.WIDTH(8), .DEPTH(4)) bus_lsb ();

   w_bit_serializer #(.WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   w_bit_serializer #(.WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .bus(bus_lsb));

   // Downstream Q6 sequence detector, z=1 in states E and F
   typedef enum logic [2:0] {QA, QB, QC, QD, QE, QF} q_t;
   q_t   q;
   logic z;
   assign z = (q == QE) || (q == QF);

   always_ff @(posedge clk) begin
      if (reset) q <= QA;
      else begin
         case (q)
            QA: q <= bus.w ? QA : QB;
            QB: q <= bus.w ? QD : QC;
            QC: q <= bus.w ? QD : QE;
            QD: q <= bus.w ? QA : QF;
            QE: q <= bus.w ? QD : QE;
            QF: q <= bus.w ? QD : QC;
            default: q <= QA;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus_lsb.in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.w !== 1'b1) begin failures++; $display("[TB] FAIL reset_w: got %b expected 1", bus.w); end
      checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL reset_active: got %b expected 0", bus.w_active); end
      checks++; if (bus.fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.fifo_level); end
      checks++; if (bus.words_sent !== 16'd0) begin failures++; $display("[TB] FAIL reset_sent: got %0d expected 0", bus.words_sent); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus_lsb.w !== 1'b1) begin failures++; $display("[TB] FAIL reset_lsb_w: got %b expected 1", bus_lsb.w); end
   endtask

   task automatic test_single();
      logic [7:0] word;
      word = 8'b0011_0101;
      do_reset();
      bus.in_data  = word;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL single_level: got %0d expected 1", bus.fifo_level); end
      checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL single_active_e0: got %b expected 0", bus.w_active); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (bus.w !== word[7-i]) begin failures++; $display("[TB] FAIL single_bit%0d: got %b expected %b", i, bus.w, word[7-i]); end
         checks++; if (bus.w_active !== 1'b1) begin failures++; $display("[TB] FAIL single_active%0d: got %b expected 1", i, bus.w_active); end
      end
      tick();
      checks++; if (bus.w !== 1'b1) begin failures++; $display("[TB] FAIL single_idle_w: got %b expected 1", bus.w); end
      checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_active: got %b expected 0", bus.w_active); end
      checks++; if (bus.words_sent !== 16'd1) begin failures++; $display("[TB] FAIL single_sent: got %0d expected 1", bus.words_sent); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] pair;
      logic [15:0] exp_sent;
      pair = 16'hA53C;
      do_reset();
      bus.in_data  = 8'hA5;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data  = 8'h3C;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.w !== pair[15]) begin failures++; $display("[TB] FAIL b2b_bit_e1: got %b expected %b", bus.w, pair[15]); end
      for (int e = 2; e <= 17; e++) begin
         tick();
         if (e <= 16) begin
            checks++; if (bus.w !== pair[16-e]) begin failures++; $display("[TB] FAIL b2b_bit_e%0d: got %b expected %b", e, bus.w, pair[16-e]); end
            checks++; if (bus.w_active !== 1'b1) begin failures++; $display("[TB] FAIL b2b_active_e%0d: got %b expected 1", e, bus.w_active); end
         end else begin
            checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_active: got %b expected 0", bus.w_active); end
         end
         exp_sent = (e >= 17) ? 16'd2 : (e >= 9) ? 16'd1 : 16'd0;
         checks++; if (bus.words_sent !== exp_sent) begin failures++; $display("[TB] FAIL b2b_sent_e%0d: got %0d expected %0d", e, bus.words_sent, exp_sent); end
      end
   endtask

   task automatic test_full();
      logic [7:0] exp_words [6];
      logic [7:0] cur;
      logic       exp_ready;
      logic [2:0] exp_level;
      exp_words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h1A};
      do_reset();
      for (int e = 0; e <= 49; e++) begin
         if (e <= 10) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + e);
            exp_ready = (e <= 4) || (e >= 10);
            checks++; if (bus.in_ready !== exp_ready) begin failures++; $display("[TB] FAIL full_ready_e%0d: got %b expected %b", e, bus.in_ready, exp_ready); end
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         if (e >= 1 && e <= 48) begin
            cur = exp_words[(e-1)/8];
            checks++; if (bus.w !== cur[7-((e-1)%8)]) begin failures++; $display("[TB] FAIL full_bit_e%0d: got %b expected %b", e, bus.w, cur[7-((e-1)%8)]); end
            checks++; if (bus.w_active !== 1'b1) begin failures++; $display("[TB] FAIL full_active_e%0d: got %b expected 1", e, bus.w_active); end
         end
         if (e == 4 || e == 9 || e == 10 || e == 17) begin
            exp_level = (e == 9 || e == 17) ? 3'd3 : 3'd4;
            checks++; if (bus.fifo_level !== exp_level) begin failures++; $display("[TB] FAIL full_level_e%0d: got %0d expected %0d", e, bus.fifo_level, exp_level); end
         end
         if (e == 49) begin
            checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL full_end_active: got %b expected 0", bus.w_active); end
            checks++; if (bus.words_sent !== 16'd6) begin failures++; $display("[TB] FAIL full_sent: got %0d expected 6", bus.words_sent); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b1;
      tick();
      tick();
      tick();
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.fifo_level !== 3'd2) begin failures++; $display("[TB] FAIL mid_level_pre: got %0d expected 2", bus.fifo_level); end
      checks++; if (bus.w_active !== 1'b1) begin failures++; $display("[TB] FAIL mid_active_pre: got %b expected 1", bus.w_active); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.w !== 1'b1) begin failures++; $display("[TB] FAIL mid_w: got %b expected 1", bus.w); end
      checks++; if (bus.w_active !== 1'b0) begin failures++; $display("[TB] FAIL mid_active: got %b expected 0", bus.w_active); end
      checks++; if (bus.fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL mid_level: got %0d expected 0", bus.fifo_level); end
      checks++; if (bus.words_sent !== 16'd0) begin failures++; $display("[TB] FAIL mid_sent: got %0d expected 0", bus.words_sent); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready: got %b expected 1", bus.in_ready); end
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++; if (bus.w_active !== 1'b0 || bus.w !== 1'b1) begin failures++; $display("[TB] FAIL mid_quiet%0d: got w=%b active=%b expected w=1 active=0", i, bus.w, bus.w_active); end
      end
   endtask

   task automatic test_lsb_first();
      logic [15:0] pair;
      pair = 16'hB401;
      do_reset();
      bus_lsb.in_data  = 8'h01;
      bus_lsb.in_valid = 1'b1;
      tick();
      bus_lsb.in_data  = 8'hB4;
      tick();
      bus_lsb.in_valid = 1'b0;
      checks++; if (bus_lsb.w !== pair[0]) begin failures++; $display("[TB] FAIL lsb_bit_e1: got %b expected %b", bus_lsb.w, pair[0]); end
      for (int e = 2; e <= 17; e++) begin
         tick();
         if (e <= 16) begin
            checks++; if (bus_lsb.w !== pair[e-1]) begin failures++; $display("[TB] FAIL lsb_bit_e%0d: got %b expected %b", e, bus_lsb.w, pair[e-1]); end
         end else begin
            checks++; if (bus_lsb.words_sent !== 16'd2) begin failures++; $display("[TB] FAIL lsb_sent: got %0d expected 2", bus_lsb.words_sent); end
            checks++; if (bus_lsb.w !== 1'b1) begin failures++; $display("[TB] FAIL lsb_idle_w: got %b expected 1", bus_lsb.w); end
         end
      end
   endtask

   task automatic test_q6_chain();
      q_t   exp_q [11];
      logic exp_z;
      exp_q = '{QA, QA, QA, QB, QC, QE, QD, QA, QA, QA, QA};
      do_reset();
      bus.in_data  = 8'b1000_1111;
      bus.in_valid = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         tick();
         bus.in_valid = 1'b0;
         exp_z = (e == 5);
         checks++; if (q !== exp_q[e]) begin failures++; $display("[TB] FAIL q6_state_e%0d: got %0d expected %0d", e, q, exp_q[e]); end
         checks++; if (z !== exp_z) begin failures++; $display("[TB] FAIL q6_z_e%0d: got %b expected %b", e, z, exp_z); end
      end
   endtask

   initial begin
      bus.in_data      = '0;
      bus.in_valid     = 1'b0;
      bus_lsb.in_data  = '0;
      bus_lsb.in_valid = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_lsb_first();
      test_q6_chain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
